stream_downsizer: RTL and testbench

//  Read-side stage for fifo_v3: pops wide words from the FIFO's pop/empty port and serializes each

---
 rtl/stream_downsizer_pkg.sv | 10 +
 rtl/stream_downsizer.sv | 119 +++++++++++
 tb/tb_stream_downsizer.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_downsizer_pkg.sv
// Shared types for the stream_downsizer read-side serializer.
package stream_downsizer_pkg;

  // IDLE: no word held. SERIAL: a word is held and its beats are being emitted.
  typedef enum logic {
    IDLE,
    SERIAL
  } state_e;

endpackage : stream_downsizer_pkg

// File: rtl/stream_downsizer.sv
// stream_downsizer: pops wide words from a fifo_v3 pop/empty port and emits each one as RATIO
// narrow beats on a valid/ready stream, LSB beat first, with last_o on the final beat.
// A new word is popped on the last beat's handshake, so back-to-back words stream without bubbles.
// Optional feature: define STREAM_DOWNSIZER_PARITY_EN to add parity_o (even parity of data_o).
module stream_downsizer
  import stream_downsizer_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic [IN_WIDTH-1:0]  fifo_data_i,
  input  logic                 fifo_empty_i,
  output logic                 fifo_pop_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [OUT_WIDTH-1:0] data_o,
  output logic                 last_o,
`ifdef STREAM_DOWNSIZER_PARITY_EN
  output logic                 parity_o,
`endif
  output logic                 busy_o
);

  localparam int unsigned RATIO     = IN_WIDTH / OUT_WIDTH;
  localparam int unsigned CNT_WIDTH = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(RATIO - 1);

  state_e                state_q, state_d;
  logic [IN_WIDTH-1:0]   word_q, word_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  handshake;
  logic [OUT_WIDTH-1:0]  beat;

  // Beat select: explicit compare per slot keeps non-power-of-2 ratios in range.
  always_comb begin
    beat = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (cnt_q == CNT_WIDTH'(i)) begin
        beat = word_q[i*OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end

  // Stream outputs and the FIFO pop; pop is suppressed by flush and never issued while empty.
  always_comb begin
    valid_o    = (state_q == SERIAL);
    data_o     = beat;
    last_o     = valid_o & (cnt_q == LAST_CNT);
    busy_o     = (state_q != IDLE);
    handshake  = valid_o & ready_i;
    fifo_pop_o = ~flush_i & ~fifo_empty_i & ((state_q == IDLE) | (handshake & last_o));
  end

`ifdef STREAM_DOWNSIZER_PARITY_EN
  // Parity only meaningful alongside valid_o; held low otherwise.
  always_comb begin
    parity_o = valid_o & (^data_o);
  end
`endif

  // Next-state: flush wins; otherwise advance the beat counter or reload on the last beat.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fifo_pop_o) begin
            state_d = SERIAL;
            word_d  = fifo_data_i;
            cnt_d   = '0;
          end
        end
        SERIAL: begin
          if (handshake) begin
            if (!last_o) begin
              cnt_d = cnt_q + 1'b1;
            end else if (fifo_pop_o) begin
              word_d = fifo_data_i;
              cnt_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, held word and beat counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      word_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
    end
  end

  // Interface invariants.
  a_no_pop_when_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
    fifo_pop_o |-> !fifo_empty_i);
  a_valid_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_o && !ready_i && !flush_i) |=> (valid_o && $stable(data_o) && $stable(last_o)));
  a_cnt_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
    cnt_q <= LAST_CNT);

endmodule : stream_downsizer

// File: tb/tb_stream_downsizer.sv
// Directed bench for stream_downsizer: 32->8 main instance, plus 24->8 and 8->8 instances.
// Honours STREAM_DOWNSIZER_PARITY_EN when defined.
module tb_stream_downsizer;

  logic clk;
  logic rst_n;

  // Main instance (RATIO=4).
  logic        flush;
  logic [31:0] fdata;
  logic        fempty;
  logic        pop;
  logic        valid;
  logic        ready;
  logic [7:0]  data;
  logic        last;
  logic        busy;
  logic        parity;

  // RATIO=3 instance.
  logic [23:0] r3_fdata;
  logic        r3_fempty;
  logic        r3_pop;
  logic        r3_valid;
  logic        r3_ready;
  logic [7:0]  r3_data;
  logic        r3_last;
  logic        r3_busy;
  logic        r3_parity;

  // RATIO=1 instance.
  logic [7:0]  r1_fdata;
  logic        r1_fempty;
  logic        r1_pop;
  logic        r1_valid;
  logic        r1_ready;
  logic [7:0]  r1_data;
  logic        r1_last;
  logic        r1_busy;
  logic        r1_parity;

  int n_checks;
  int n_errors;

  stream_downsizer #(.IN_WIDTH(32), .OUT_WIDTH(8)) u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush),
    .fifo_data_i  (fdata),
    .fifo_empty_i (fempty),
    .fifo_pop_o   (pop),
    .valid_o      (valid),
    .ready_i      (ready),
    .data_o       (data),
    .last_o       (last),
`ifdef STREAM_DOWNSIZER_PARITY_EN
    .parity_o     (parity),
`endif
    .busy_o       (busy)
  );

  stream_downsizer #(.IN_WIDTH(24), .OUT_WIDTH(8)) u_dut_r3 (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (1'b0),
    .fifo_data_i  (r3_fdata),
    .fifo_empty_i (r3_fempty),
    .fifo_pop_o   (r3_pop),
    .valid_o      (r3_valid),
    .ready_i      (r3_ready),
    .data_o       (r3_data),
    .last_o       (r3_last),
`ifdef STREAM_DOWNSIZER_PARITY_EN
    .parity_o     (r3_parity),
`endif
    .busy_o       (r3_busy)
  );

  stream_downsizer #(.IN_WIDTH(8), .OUT_WIDTH(8)) u_dut_r1 (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (1'b0),
    .fifo_data_i  (r1_fdata),
    .fifo_empty_i (r1_fempty),
    .fifo_pop_o   (r1_pop),
    .valid_o      (r1_valid),
    .ready_i      (r1_ready),
    .data_o       (r1_data),
    .last_o       (r1_last),
`ifdef STREAM_DOWNSIZER_PARITY_EN
    .parity_o     (r1_parity),
`endif
    .busy_o       (r1_busy)
  );

`ifndef STREAM_DOWNSIZER_PARITY_EN
  assign parity    = 1'b0;
  assign r3_parity = 1'b0;
  assign r1_parity = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then driven and outputs settle before checks.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Check the main instance's stream outputs in one go.
  task automatic beat(input string tag, input logic v, input logic [7:0] d, input logic l,
                      input logic p);
    #1;
    chk({tag, ".valid"}, 32'(valid), 32'(v));
    if (v) begin
      chk({tag, ".data"}, 32'(data), 32'(d));
    end
    chk({tag, ".last"}, 32'(last), 32'(l));
    chk({tag, ".pop"}, 32'(pop), 32'(p));
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    fdata     = '0;
    fempty    = 1'b1;
    ready     = 1'b0;
    r3_fdata  = '0;
    r3_fempty = 1'b1;
    r3_ready  = 1'b0;
    r1_fdata  = '0;
    r1_fempty = 1'b1;
    r1_ready  = 1'b0;

    // Reset state.
    #3;
    chk("rst.valid", 32'(valid), 32'd0);
    chk("rst.data", 32'(data), 32'd0);
    chk("rst.last", 32'(last), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.pop", 32'(pop), 32'd0);
    chk("rst.r1_last", 32'(r1_last), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single word, free-running sink.
    tick();
    fdata  = 32'hDDCC_BBAA;
    fempty = 1'b0;
    ready  = 1'b1;
    beat("t1.t0", 1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    fempty = 1'b1;
    beat("t1.b0", 1'b1, 8'hAA, 1'b0, 1'b0);
    chk("t1.busy", 32'(busy), 32'd1);
`ifdef STREAM_DOWNSIZER_PARITY_EN
    chk("t1.parity_aa", 32'(parity), 32'd0);
`endif
    tick();
    beat("t1.b1", 1'b1, 8'hBB, 1'b0, 1'b0);
    tick();
    beat("t1.b2", 1'b1, 8'hCC, 1'b0, 1'b0);
    tick();
    beat("t1.b3", 1'b1, 8'hDD, 1'b1, 1'b0);
    tick();
    beat("t1.idle", 1'b0, 8'h00, 1'b0, 1'b0);
    chk("t1.busy_idle", 32'(busy), 32'd0);

    // 2: two words back to back, second pop on the first word's last beat.
    fdata  = 32'h4433_2211;
    fempty = 1'b0;
    beat("t2.t0", 1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    fdata = 32'h8877_6655;
    beat("t2.b0", 1'b1, 8'h11, 1'b0, 1'b0);
    tick();
    beat("t2.b1", 1'b1, 8'h22, 1'b0, 1'b0);
    tick();
    beat("t2.b2", 1'b1, 8'h33, 1'b0, 1'b0);
    tick();
    beat("t2.b3", 1'b1, 8'h44, 1'b1, 1'b1);
    tick();
    fempty = 1'b1;
    beat("t2.b4", 1'b1, 8'h55, 1'b0, 1'b0);
    tick();
    beat("t2.b5", 1'b1, 8'h66, 1'b0, 1'b0);
    tick();
    beat("t2.b6", 1'b1, 8'h77, 1'b0, 1'b0);
    tick();
    beat("t2.b7", 1'b1, 8'h88, 1'b1, 1'b0);
    tick();
    beat("t2.idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // 3: stall on beat BB for three cycles with the next word already waiting.
    fdata  = 32'hDDCC_BBAA;
    fempty = 1'b0;
    beat("t3.t0", 1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    fdata = 32'h0403_0201;
    beat("t3.b0", 1'b1, 8'hAA, 1'b0, 1'b0);
    tick();
    ready = 1'b0;
    beat("t3.b1", 1'b1, 8'hBB, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      beat("t3.stall", 1'b1, 8'hBB, 1'b0, 1'b0);
    end
    ready = 1'b1;
    tick();
    beat("t3.b2", 1'b1, 8'hCC, 1'b0, 1'b0);
    tick();
    beat("t3.b3", 1'b1, 8'hDD, 1'b1, 1'b1);
    tick();
    fempty = 1'b1;
    beat("t3.w2b0", 1'b1, 8'h01, 1'b0, 1'b0);

    // 4: flush at beat 03 of word 04030201 while the next word is queued.
    tick();
    beat("t4.b1", 1'b1, 8'h02, 1'b0, 1'b0);
    tick();
    fdata  = 32'h0D0C_0B0A;
    fempty = 1'b0;
    flush  = 1'b1;
    beat("t4.flush", 1'b1, 8'h03, 1'b0, 1'b0);
    tick();
    flush = 1'b0;
    beat("t4.idle", 1'b0, 8'h00, 1'b0, 1'b1);
    chk("t4.busy", 32'(busy), 32'd0);
    tick();
    fempty = 1'b1;
    beat("t4.b0", 1'b1, 8'h0A, 1'b0, 1'b0);
    tick();
    beat("t4.b1n", 1'b1, 8'h0B, 1'b0, 1'b0);
    tick();
    beat("t4.b2n", 1'b1, 8'h0C, 1'b0, 1'b0);
    tick();
    beat("t4.b3n", 1'b1, 8'h0D, 1'b1, 1'b0);
    tick();

    // 5: empty FIFO stays quiet; then an async reset mid-word clears the outputs.
    for (int k = 0; k < 3; k++) begin
      tick();
      beat("t5.empty", 1'b0, 8'h00, 1'b0, 1'b0);
    end
    fdata  = 32'hCAFE_F00D;
    fempty = 1'b0;
    beat("t5.t0", 1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    fempty = 1'b1;
    beat("t5.b0", 1'b1, 8'h0D, 1'b0, 1'b0);
    tick();
    beat("t5.b1", 1'b1, 8'hF0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t5.rst_valid", 32'(valid), 32'd0);
    chk("t5.rst_data", 32'(data), 32'd0);
    chk("t5.rst_last", 32'(last), 32'd0);
    chk("t5.rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 6a: RATIO=3, counter wraps 2->0 across a back-to-back reload.
    tick();
    r3_fdata  = 24'h33_2211;
    r3_fempty = 1'b0;
    r3_ready  = 1'b1;
    #1;
    chk("t6.r3_pop0", 32'(r3_pop), 32'd1);
    tick();
    r3_fempty = 1'b1;
    #1;
    chk("t6.r3_b0", 32'(r3_data), 32'h11);
    chk("t6.r3_l0", 32'(r3_last), 32'd0);
    tick();
    #1;
    chk("t6.r3_b1", 32'(r3_data), 32'h22);
    tick();
    r3_fdata  = 24'h07_0605;
    r3_fempty = 1'b0;
    #1;
    chk("t6.r3_b2", 32'(r3_data), 32'h33);
    chk("t6.r3_l2", 32'(r3_last), 32'd1);
    chk("t6.r3_pop1", 32'(r3_pop), 32'd1);
    tick();
    r3_fempty = 1'b1;
    #1;
    chk("t6.r3_wrap_data", 32'(r3_data), 32'h05);
    chk("t6.r3_wrap_last", 32'(r3_last), 32'd0);
    chk("t6.r3_wrap_valid", 32'(r3_valid), 32'd1);
    tick();
    #1;
    chk("t6.r3_b4", 32'(r3_data), 32'h06);
`ifdef STREAM_DOWNSIZER_PARITY_EN
    chk("t6.r3_par06", 32'(r3_parity), 32'd0);
`endif
    tick();
    #1;
    chk("t6.r3_b5", 32'(r3_data), 32'h07);
    chk("t6.r3_l5", 32'(r3_last), 32'd1);
`ifdef STREAM_DOWNSIZER_PARITY_EN
    chk("t6.r3_par07", 32'(r3_parity), 32'd1);
`endif
    tick();
    #1;
    chk("t6.r3_idle", 32'(r3_valid), 32'd0);

    // 6b: RATIO=1, every beat is last and words stream back to back.
    r1_fdata  = 8'h07;
    r1_fempty = 1'b0;
    r1_ready  = 1'b1;
    #1;
    chk("t6.r1_pop0", 32'(r1_pop), 32'd1);
    tick();
    r1_fdata = 8'h5A;
    #1;
    chk("t6.r1_b0", 32'(r1_data), 32'h07);
    chk("t6.r1_l0", 32'(r1_last), 32'd1);
    chk("t6.r1_pop1", 32'(r1_pop), 32'd1);
`ifdef STREAM_DOWNSIZER_PARITY_EN
    chk("t6.r1_par07", 32'(r1_parity), 32'd1);
`endif
    tick();
    r1_fempty = 1'b1;
    #1;
    chk("t6.r1_b1", 32'(r1_data), 32'h5A);
    chk("t6.r1_l1", 32'(r1_last), 32'd1);
    chk("t6.r1_v1", 32'(r1_valid), 32'd1);
    tick();
    #1;
    chk("t6.r1_idle", 32'(r1_valid), 32'd0);
    chk("t6.r1_busy", 32'(r1_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_stream_downsizer
